// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU definitions for the memory-port arbiter: FSM encoding and the
// default fetch-starvation limit.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   localparam int unsigned STREAK_MAX_DEFAULT = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data wins by default; a streak counter forces a fetch grant once data has starved it.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STREAK_MAX = STREAK_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   localparam int unsigned SW = (STREAK_MAX < 4) ? 2 : $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_LIMIT = SW'(STREAK_MAX);

   arb_state_t    state;
   arb_state_t    state_next;
   logic [SW-1:0] streak;
   logic          data_req;
   logic          fetch_due;
   logic          grant_d;
   logic          grant_i;
   logic          finish;

   assign data_req  = d_read | d_write;
   assign fetch_due = if_req && (streak == STREAK_LIMIT);
   assign stall     = (if_req & ~if_done) | (data_req & ~d_done);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A done pulse blocks granting, which spaces back-to-back transactions by one idle cycle.
   always_comb begin
      state_next = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (!(if_done || d_done)) begin
               if (data_req && !fetch_due) begin
                  grant_d    = 1'b1;
                  state_next = D_BUSY;
               end else if (if_req) begin
                  grant_i    = 1'b1;
                  state_next = I_BUSY;
               end
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_ready) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         streak    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req) begin
               streak <= streak + 1'b1;
            end
         end else if (grant_i) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            streak   <= '0;
         end
         // mem_we still holds the latched direction, so stores leave d_rdata alone.
         if (finish) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (state == I_BUSY) begin
               if_rdata <= mem_rdata;
               if_done  <= 1'b1;
            end else begin
               d_done <= 1'b1;
               if (!mem_we) begin
                  d_rdata <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory answers requests and
// a scoreboard of expected read data is checked whenever a done pulse appears.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        stall;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] d_q[$];
   logic [31:0] if_q[$];
   logic [31:0] last_d = '0;
   logic [31:0] last_if = '0;
   logic [31:0] ref_mem[bit [31:0]];
   logic [31:0] mem_array[bit [31:0]];
   bit          mem_auto = 1'b1;
   int          mem_lat = 0;
   int          wait_cnt = 0;

   mem_port_arbiter #(.STREAK_MAX(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] default_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural memory: answers mem_lat cycles after mem_req first rises.
   always @(negedge clk) begin
      if (mem_auto) begin
         if (mem_req && !mem_ready) begin
            if (wait_cnt >= mem_lat) begin
               mem_ready = 1'b1;
               mem_rdata = mem_array.exists(mem_addr) ? mem_array[mem_addr] : default_word(mem_addr);
               if (mem_we) mem_array[mem_addr] = mem_wdata;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Scoreboard pop on each completion pulse.
   always @(negedge clk) begin
      if (reset_n && d_done) begin
         check_output("d_done_expected", 32'(d_q.size() != 0), 32'd1);
         if (d_q.size() != 0) check_output("d_rdata", d_rdata, d_q.pop_front());
      end
      if (reset_n && if_done) begin
         check_output("if_done_expected", 32'(if_q.size() != 0), 32'd1);
         if (if_q.size() != 0) check_output("if_rdata", if_rdata, if_q.pop_front());
      end
   end

   task automatic apply_stimulus(input bit is_d, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int lat, input string tag);
      int cyc;
      bit done_seen;
      logic [31:0] exp;
      mem_lat = lat;
      if (is_d) begin
         if (wr) begin
            ref_mem[addr] = wdata;
            d_q.push_back(last_d);
         end else begin
            exp = ref_read(addr);
            d_q.push_back(exp);
            last_d = exp;
         end
         d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
      end else begin
         exp = ref_read(addr);
         if_q.push_back(exp);
         last_if = exp;
         if_addr = addr; if_req = 1'b1;
      end
      #1 check_output({tag, "_stall_c0"}, 32'(stall), 32'd1);
      cyc = 0;
      done_seen = 1'b0;
      while (!done_seen && cyc < lat + 10) begin
         @(negedge clk);
         cyc++;
         if (is_d ? d_done : if_done) begin
            done_seen = 1'b1;
            check_output({tag, "_latency"}, 32'(cyc), 32'(lat + 2));
         end else begin
            check_output({tag, "_stall"}, 32'(stall), 32'd1);
            check_output({tag, "_mem_req"}, 32'(mem_req), 32'd1);
            check_output({tag, "_mem_addr"}, mem_addr, addr);
            check_output({tag, "_mem_we"}, 32'(mem_we), 32'(is_d && wr));
            if (is_d && wr) check_output({tag, "_mem_wdata"}, mem_wdata, wdata);
         end
      end
      check_output({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      d_read = 1'b0; d_write = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check_output({tag, "_single_pulse"}, 32'(is_d ? d_done : if_done), 32'd0);
   endtask

   initial begin
      bit order_q[$];
      int cnt;
      int cyc;
      ref_mem[32'h40] = 32'hDEADBEEF;
      mem_array[32'h40] = 32'hDEADBEEF;

      // Reset state
      #12;
      check_output("rst_mem_req", 32'(mem_req), 32'd0);
      check_output("rst_mem_we", 32'(mem_we), 32'd0);
      check_output("rst_mem_addr", mem_addr, 32'd0);
      check_output("rst_mem_wdata", mem_wdata, 32'd0);
      check_output("rst_if_rdata", if_rdata, 32'd0);
      check_output("rst_d_rdata", d_rdata, 32'd0);
      check_output("rst_done", 32'({if_done, d_done}), 32'd0);
      check_output("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 0, "load1");
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 20, "load_slow");
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80, 32'h12345678, 3, "store");
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1, "load_back");
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1, "fetch");

      // Stray mem_ready while idle
      mem_auto = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_ready = 1'b0;
      check_output("idle_ready_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      check_output("idle_ready_done", 32'({if_done, d_done}), 32'd0);
      check_output("idle_ready_if_rdata", if_rdata, last_if);
      check_output("idle_ready_d_rdata", d_rdata, last_d);
      mem_auto = 1'b1;

      // Fetch and data competing continuously
      mem_lat = 0;
      order_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) d_q.push_back(ref_read(32'h40));
      for (int i = 0; i < 2; i++) if_q.push_back(ref_read(32'h300));
      last_d = ref_read(32'h40);
      last_if = ref_read(32'h300);
      d_read = 1'b1; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h300;
      cnt = 0;
      cyc = 0;
      while (cnt < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (d_done || if_done) begin
            check_output("streak_order_fetch", 32'(if_done), 32'(order_q.pop_front()));
            cnt++;
         end
      end
      d_read = 1'b0; if_req = 1'b0;
      check_output("streak_grants", 32'(cnt), 32'd8);
      @(negedge clk);

      // Reset during a data transaction
      mem_auto = 1'b0;
      d_read = 1'b1; d_addr = 32'h500;
      @(negedge clk);
      check_output("rstmid_busy_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      d_read = 1'b0;
      #1;
      check_output("rstmid_mem_req", 32'(mem_req), 32'd0);
      check_output("rstmid_mem_addr", mem_addr, 32'd0);
      check_output("rstmid_d_rdata", d_rdata, 32'd0);
      check_output("rstmid_if_rdata", if_rdata, 32'd0);
      last_d = '0;
      last_if = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         check_output("rstmid_no_done", 32'(d_done), 32'd0);
         check_output("rstmid_idle_req", 32'(mem_req), 32'd0);
      end
      mem_auto = 1'b1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 0, "after_reset");

      check_output("d_queue_drained", 32'(d_q.size()), 32'd0);
      check_output("if_queue_drained", 32'(if_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
